uart_frame_parser: RTL and testbench

Byte-stream frame parser that sits directly downstream of the UART receiver. It delineates command frames (SOF, CMD, ADDR, LEN, payload, XOR checksum) in the received byte stream, latches the header fields, forwards payload bytes through a registered valid/ready port, and reports one completion status per frame. Inter-byte timeout recovery keeps a lost or corrupted byte from hanging the parser.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_parser_if.sv | 30 +++
 rtl/uart_frame_timer.sv | 28 ++
 rtl/uart_frame_parser.sv | 131 +++++++++++++
 tb/tb_uart_frame_parser.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  typedef enum logic [1:0] {
    DONE_OK      = 2'd0,
    DONE_BAD_CHK = 2'd1,
    DONE_BAD_LEN = 2'd2,
    DONE_TIMEOUT = 2'd3
  } done_status_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in, header/payload/status-out bundle of the frame parser.
// master = byte source and payload consumer, slave = parser.
interface uart_frame_parser_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] frm_cmd;
  logic [7:0] frm_addr;
  logic [7:0] frm_len;
  logic       hdr_valid;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       done_valid;
  logic [1:0] done_status;

  modport master (
    output in_data, in_valid, pl_ready,
    input  in_ready, frm_cmd, frm_addr, frm_len, hdr_valid,
           pl_data, pl_valid, done_valid, done_status
  );

  modport slave (
    input  in_data, in_valid, pl_ready,
    output in_ready, frm_cmd, frm_addr, frm_len, hdr_valid,
           pl_data, pl_valid, done_valid, done_status
  );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; expired flags the last idle cycle before abort.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Delineates SOF/CMD/ADDR/LEN/payload/XOR frames from the UART byte stream.
//   state      | meaning
//   ST_IDLE    | hunting for SOF, other bytes dropped
//   ST_CMD     | next byte is the command
//   ST_ADDR    | next byte is the address
//   ST_LEN     | next byte is the payload length, checked against MAX_LEN
//   ST_PAYLOAD | forwarding payload bytes, rem_cnt bytes left
//   ST_CHK     | next byte is the XOR checksum
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF         = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50_000
) (
  input logic               clk,
  input logic               rst,
  uart_frame_parser_if.slave bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t       state;
  done_status_t done_status;
  logic [7:0]   frm_cmd, frm_addr, frm_len, pl_data, chk_sum, rem_cnt;
  logic         hdr_valid, pl_valid, done_valid;
  logic         in_ready, accept, expired, timeout;

  always_comb begin
    in_ready = 1'b1;
    case (state)
      ST_PAYLOAD: in_ready = !pl_valid || bus.pl_ready;
      // hold the checksum byte until the last payload byte has left
      ST_CHK:     in_ready = !pl_valid;
      default:    in_ready = 1'b1;
    endcase
  end

  assign accept  = bus.in_valid && in_ready;
  assign timeout = expired && (state != ST_IDLE) && !accept;

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frm_cmd     <= '0;
      frm_addr    <= '0;
      frm_len     <= '0;
      pl_data     <= '0;
      pl_valid    <= 1'b0;
      hdr_valid   <= 1'b0;
      done_valid  <= 1'b0;
      done_status <= DONE_OK;
      chk_sum     <= '0;
      rem_cnt     <= '0;
    end else begin
      hdr_valid  <= 1'b0;
      done_valid <= 1'b0;
      if (pl_valid && bus.pl_ready) pl_valid <= 1'b0;

      if (timeout) begin
        done_valid  <= 1'b1;
        done_status <= DONE_TIMEOUT;
        state       <= ST_IDLE;
      end else if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (bus.in_data == SOF) begin
              chk_sum <= '0;
              state   <= ST_CMD;
            end
          end
          ST_CMD: begin
            frm_cmd <= bus.in_data;
            chk_sum <= chk_sum ^ bus.in_data;
            state   <= ST_ADDR;
          end
          ST_ADDR: begin
            frm_addr <= bus.in_data;
            chk_sum  <= chk_sum ^ bus.in_data;
            state    <= ST_LEN;
          end
          ST_LEN: begin
            frm_len <= bus.in_data;
            chk_sum <= chk_sum ^ bus.in_data;
            rem_cnt <= bus.in_data;
            if (bus.in_data > MAX_LEN_B) begin
              done_valid  <= 1'b1;
              done_status <= DONE_BAD_LEN;
              state       <= ST_IDLE;
            end else begin
              hdr_valid <= 1'b1;
              state     <= (bus.in_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pl_data  <= bus.in_data;
            pl_valid <= 1'b1;
            chk_sum  <= chk_sum ^ bus.in_data;
            rem_cnt  <= rem_cnt - 8'd1;
            if (rem_cnt == 8'd1) state <= ST_CHK;
          end
          ST_CHK: begin
            done_valid  <= 1'b1;
            done_status <= (bus.in_data == chk_sum) ? DONE_OK : DONE_BAD_CHK;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.frm_cmd     = frm_cmd;
  assign bus.frm_addr    = frm_addr;
  assign bus.frm_len     = frm_len;
  assign bus.hdr_valid   = hdr_valid;
  assign bus.pl_data     = pl_data;
  assign bus.pl_valid    = pl_valid;
  assign bus.done_valid  = done_valid;
  assign bus.done_status = done_status;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Frame parser bench: directed frames with literal expectations plus random
// frames checked every cycle against a byte-position frame model.
module tb_uart_frame_parser;

  localparam int TO   = 100;
  localparam int MAXL = 16;

  logic clk, rst;
  uart_frame_parser_if bus();

  uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0, n_total = 0;
  int pr_mode = 0;

  // frame model: bytes of the current frame after SOF, kept by position
  bit         in_frame = 0;
  logic [7:0] fb[$];
  int         idle_cnt = 0;
  bit         exp_hdr = 0, exp_done = 0, m_plv = 0;
  logic [1:0] exp_st = 0;
  logic [7:0] m_pld = 0, m_cmd = 0, m_addr = 0, m_flen = 0;
  int         ir_low = 0;

  logic [23:0] hdr_log[$];
  logic [7:0]  pl_log[$];
  logic [1:0]  done_log[$];
  int          hb = 0, pb = 0, db = 0;
  logic [23:0] lit_hdr[$];
  logic [7:0]  lit_pl[$];
  logic [1:0]  lit_done[$];
  logic [7:0]  tx_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // payload consumer
  initial begin
    int ph;
    ph = 0;
    bus.pl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (pr_mode)
        1: begin bus.pl_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        2: bus.pl_ready = 1'($urandom_range(0, 1));
        3: bus.pl_ready = 1'b0;
        default: bus.pl_ready = 1'b1;
      endcase
    end
  end

  // model + compare, one pass per negedge
  initial begin
    bit         acc, plv_next, exp_ir;
    int         n, flen;
    logic [7:0] b, x;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0; fb.delete(); idle_cnt = 0;
        exp_hdr = 0; exp_done = 0; exp_st = 0; m_plv = 0;
        m_pld = 0; m_cmd = 0; m_addr = 0; m_flen = 0;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst pl_valid", 32'(bus.pl_valid), 32'd0);
        chk("rst pl_data", 32'(bus.pl_data), 32'd0);
        chk("rst hdr_valid", 32'(bus.hdr_valid), 32'd0);
        chk("rst done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst done_status", 32'(bus.done_status), 32'd0);
        chk("rst frm", {8'd0, bus.frm_cmd, bus.frm_addr, bus.frm_len}, 32'd0);
        continue;
      end

      n    = fb.size();
      flen = (n >= 3) ? int'(fb[2]) : 0;
      if (in_frame && n >= 3 && flen > 0 && n < 3 + flen) exp_ir = !m_plv || bus.pl_ready;
      else if (in_frame && n >= 3 && n == 3 + flen)        exp_ir = !m_plv;
      else                                                 exp_ir = 1'b1;

      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("pl_valid", 32'(bus.pl_valid), 32'(m_plv));
      if (m_plv) chk("pl_data", 32'(bus.pl_data), 32'(m_pld));
      chk("hdr_valid", 32'(bus.hdr_valid), 32'(exp_hdr));
      chk("done_valid", 32'(bus.done_valid), 32'(exp_done));
      if (exp_done) chk("done_status", 32'(bus.done_status), 32'(exp_st));
      if (bus.done_valid) chk("done_after_payload", 32'(bus.pl_valid), 32'd0);
      chk("frm_cmd", 32'(bus.frm_cmd), 32'(m_cmd));
      chk("frm_addr", 32'(bus.frm_addr), 32'(m_addr));
      chk("frm_len", 32'(bus.frm_len), 32'(m_flen));

      if (bus.hdr_valid) hdr_log.push_back({bus.frm_cmd, bus.frm_addr, bus.frm_len});
      if (bus.pl_valid && bus.pl_ready) pl_log.push_back(bus.pl_data);
      if (bus.done_valid) done_log.push_back(bus.done_status);
      if (bus.pl_valid && !bus.pl_ready && !bus.in_ready) ir_low++;

      acc      = bus.in_valid && exp_ir;
      exp_hdr  = 0;
      exp_done = 0;
      plv_next = m_plv && !bus.pl_ready;
      if (acc) begin
        b = bus.in_data;
        idle_cnt = 0;
        if (!in_frame) begin
          if (b == 8'hA5) begin in_frame = 1; fb.delete(); end
        end else begin
          fb.push_back(b);
          n = fb.size();
          if (n == 1) m_cmd = b;
          else if (n == 2) m_addr = b;
          else if (n == 3) begin
            m_flen = b;
            if (int'(b) > MAXL) begin exp_done = 1; exp_st = 2'd2; in_frame = 0; end
            else exp_hdr = 1;
          end else if (n <= 3 + int'(fb[2])) begin
            plv_next = 1; m_pld = b;
          end else begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x ^= fb[i];
            exp_done = 1; exp_st = (x == b) ? 2'd0 : 2'd1; in_frame = 0;
          end
        end
      end else if (in_frame) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          exp_done = 1; exp_st = 2'd3; in_frame = 0; idle_cnt = 0;
        end
      end else begin
        idle_cnt = 0;
      end
      m_plv = plv_next;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_byte: byte %0h not accepted within 2000 cycles", b);
    end
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
  endtask

  task automatic mark();
    hb = hdr_log.size();
    pb = pl_log.size();
    db = done_log.size();
  endtask

  task automatic compare_lits(input string name);
    chk({name, " hdr_count"}, 32'(hdr_log.size() - hb), 32'(lit_hdr.size()));
    foreach (lit_hdr[i]) if (hb + i < hdr_log.size()) chk({name, " hdr"}, 32'(hdr_log[hb+i]), 32'(lit_hdr[i]));
    chk({name, " pl_count"}, 32'(pl_log.size() - pb), 32'(lit_pl.size()));
    foreach (lit_pl[i]) if (pb + i < pl_log.size()) chk({name, " pl"}, 32'(pl_log[pb+i]), 32'(lit_pl[i]));
    chk({name, " done_count"}, 32'(done_log.size() - db), 32'(lit_done.size()));
    foreach (lit_done[i]) if (db + i < done_log.size()) chk({name, " done"}, 32'(done_log[db+i]), 32'(lit_done[i]));
    lit_hdr.delete();
    lit_pl.delete();
    lit_done.delete();
  endtask

  task automatic good_frame(input string name);
    mark();
    lit_hdr  = {24'h011002};
    lit_pl   = {8'hAA, 8'h55};
    lit_done = {2'd0};
    tx_q = {8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hEC};
    send_q();
    idle(3);
    compare_lits(name);
  endtask

  task automatic rand_frame();
    int         kind, len, cut;
    logic [7:0] b, x;
    logic [7:0] body[$];
    kind = $urandom_range(0, 9);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
      end
    end
    len  = (kind == 0) ? $urandom_range(17, 255) : $urandom_range(0, MAXL);
    body = {8'hA5, 8'($urandom), 8'($urandom), 8'(len)};
    if (kind != 0) begin
      x = body[1] ^ body[2] ^ body[3];
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        body.push_back(b);
        x ^= b;
      end
      body.push_back((kind == 2) ? ~x : x);
    end
    cut = (kind == 1) ? $urandom_range(1, body.size() - 1) : body.size();
    for (int i = 0; i < cut; i++) begin
      send_byte(body[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    if (kind == 1) idle(TO + $urandom_range(1, 4));
  endtask

  initial begin
    int ir0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    good_frame("good");

    mark();
    lit_hdr = {24'h022000}; lit_done = {2'd0};
    tx_q = {8'hA5, 8'h02, 8'h20, 8'h00, 8'h22};
    send_q(); idle(3);
    compare_lits("zero_len");

    mark();
    lit_hdr = {24'h022000}; lit_done = {2'd1};
    tx_q = {8'hA5, 8'h02, 8'h20, 8'h00, 8'h23};
    send_q(); idle(3);
    compare_lits("zero_len_bad_chk");

    mark();
    lit_done = {2'd2};
    tx_q = {8'hA5, 8'h03, 8'h30, 8'h11};
    send_q(); idle(3);
    compare_lits("bad_len");
    good_frame("after_bad_len");

    mark();
    lit_done = {2'd3};
    tx_q = {8'hA5, 8'h01};
    send_q(); idle(TO); idle(3);
    compare_lits("timeout");
    chk("timeout idle in_ready", 32'(bus.in_ready), 32'd1);
    good_frame("after_timeout");

    mark();
    lit_hdr = {24'h011000}; lit_done = {2'd0};
    tx_q = {8'hA5, 8'h01};
    send_q(); idle(TO - 1);
    tx_q = {8'h10, 8'h00, 8'h11};
    send_q(); idle(3);
    compare_lits("byte_at_last_idle");

    pr_mode = 1;
    ir0 = ir_low;
    mark();
    lit_hdr  = {24'h055004};
    lit_pl   = {8'h11, 8'h22, 8'h33, 8'h44};
    lit_done = {2'd0};
    tx_q = {8'hA5, 8'h05, 8'h50, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h15};
    send_q(); idle(6);
    compare_lits("backpressure");
    chk("backpressure stall seen", 32'(ir_low > ir0), 32'd1);
    pr_mode = 0;
    idle(1);

    mark();
    lit_hdr = {24'h011002}; lit_pl = {8'hAA, 8'h55}; lit_done = {2'd0};
    tx_q = {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hEC};
    send_q(); idle(3);
    compare_lits("noise");

    pr_mode = 3;
    idle(1);
    mark();
    lit_hdr = {24'h077003};
    tx_q = {8'hA5, 8'h07, 8'h70, 8'h03, 8'h99};
    send_q(); idle(2);
    chk("held payload valid", 32'(bus.pl_valid), 32'd1);
    chk("held payload data", 32'(bus.pl_data), 32'h99);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    pr_mode = 0;
    idle(3);
    compare_lits("reset_mid_payload");
    chk("post-rst pl_valid", 32'(bus.pl_valid), 32'd0);
    chk("post-rst frm", {8'd0, bus.frm_cmd, bus.frm_addr, bus.frm_len}, 32'd0);
    good_frame("after_reset");

    for (int f = 0; f < 250; f++) begin
      pr_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      rand_frame();
    end
    pr_mode = 0;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
